pdu_tx_framer: RTL and testbench

//  Transmit-side counterpart of the RX PDU generator. Takes 512-bit flits read from host memory over PCIe plus a
//  per-packet TX descriptor carrying the byte length, and rebuilds an Avalon-ST Ethernet packet (sop/eop/empty) for the MAC.

---
 rtl/pdu_tx_framer_if.sv | 36 +++
 rtl/pdu_tx_framer.sv | 154 +++++++++++++++
 tb/tb_pdu_tx_framer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdu_tx_framer_if.sv
// PDU TX framer bundle: DMA flit/descriptor side in, MAC Avalon-ST side out.
// Both directions of valid/ready handshake live here; clk/rst_n stay plain ports.
interface pdu_tx_framer_if #(
   parameter int SIZE_WIDTH = 16
);
   logic [511:0]          in_data;
   logic                  in_sop;
   logic                  in_eop;
   logic                  in_valid;
   logic                  in_ready;
   logic [SIZE_WIDTH-1:0] in_meta_size;
   logic                  in_meta_valid;
   logic                  in_meta_ready;
   logic [511:0]          out_data;
   logic                  out_sop;
   logic                  out_eop;
   logic [5:0]            out_empty;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output in_data, in_sop, in_eop, in_valid,
      output in_meta_size, in_meta_valid,
      output out_ready,
      input  in_ready, in_meta_ready,
      input  out_data, out_sop, out_eop, out_empty, out_valid
   );

   modport slave (
      input  in_data, in_sop, in_eop, in_valid,
      input  in_meta_size, in_meta_valid,
      input  out_ready,
      output in_ready, in_meta_ready,
      output out_data, out_sop, out_eop, out_empty, out_valid
   );
endinterface

// File: rtl/pdu_tx_framer.sv
// TX PDU framer: host flits + length descriptor -> Avalon-ST packet for the MAC.
// Optional PDU_TX_STATS_EN adds packet/error counters (tied to 0 otherwise).
module pdu_tx_framer #(
   parameter int SKID_DEPTH = 2,
   parameter int SIZE_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   pdu_tx_framer_if.slave bus,
   output logic [31:0]    stat_pkt_cnt,
   output logic [31:0]    stat_err_cnt
);
   localparam int RW  = SIZE_WIDTH - 5;
   localparam int CW  = $clog2(SKID_DEPTH + 1);
   localparam int SW1 = SIZE_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

   typedef struct packed {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic [5:0]   empty;
   } ent_t;

   state_t        state, state_n;
   logic [RW-1:0] rem;
   logic [5:0]    size_lo;
   logic          first;
   logic [CW-1:0] cnt, cnt_n;
   ent_t          q0, q1, ent;
   logic          in_ready_q;
   logic [511:0]  swapped;
   logic [SW1-1:0] sz_sum;
   logic          fhs, mhs, push, pop;
   logic          is_last, sz_zero, err_evt;
   logic          unused_ok;

   assign sz_sum  = {1'b0, bus.in_meta_size} + SW1'(63);
   assign sz_zero = bus.in_meta_size == '0;
   assign fhs     = bus.in_valid & in_ready_q;
   assign mhs     = bus.in_meta_valid & bus.in_meta_ready;
   assign is_last = rem == RW'(1);
   assign push    = fhs & (state == STREAM);
   assign pop     = bus.out_valid & bus.out_ready;
   // mismatch: last flit without eop, or eop before the last flit
   assign err_evt = (mhs & sz_zero) | (push & (is_last ^ bus.in_eop));

   assign bus.in_ready      = in_ready_q;
   assign bus.in_meta_ready = (state == IDLE)
                            | (push & is_last & bus.in_eop);

   assign bus.out_valid = cnt != '0;
   assign bus.out_data  = q0.data;
   assign bus.out_sop   = q0.sop;
   assign bus.out_eop   = q0.eop;
   assign bus.out_empty = q0.empty;

   always_comb begin
      swapped = '0;
      for (int i = 0; i < 64; i++)
         swapped[511-8*i -: 8] = bus.in_data[8*i +: 8];
   end

   always_comb begin
      ent.data  = swapped;
      ent.sop   = first;
      ent.eop   = is_last | bus.in_eop;
      ent.empty = is_last ? 6'd0 - size_lo : 6'd0;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (mhs) state_n = sz_zero ? DROP : STREAM;
         STREAM:
            if (push) begin
               if (is_last & ~bus.in_eop)
                  state_n = DROP;
               else if (mhs)
                  state_n = sz_zero ? DROP : STREAM;
               else if (is_last | bus.in_eop)
                  state_n = IDLE;
            end
         DROP:
            if (fhs & bus.in_eop) state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   assign cnt_n = cnt + CW'(push) - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rem        <= '0;
         size_lo    <= '0;
         first      <= 1'b0;
         cnt        <= '0;
         in_ready_q <= 1'b0;
         q0         <= '0;
         q1         <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         // registered ready: a full skid is seen one cycle early
         in_ready_q <= (state_n != IDLE)
                     & (cnt_n != CW'(SKID_DEPTH));
         if (push) begin
            rem   <= rem - RW'(1);
            first <= 1'b0;
         end
         if (mhs) begin
            rem     <= sz_sum[SIZE_WIDTH:6];
            size_lo <= bus.in_meta_size[5:0];
            first   <= 1'b1;
         end
         unique case ({push, pop})
            2'b10:
               if (cnt == '0) q0 <= ent;
               else           q1 <= ent;
            2'b01:
               q0 <= q1;
            2'b11:
               if (cnt == CW'(1)) begin
                  q0 <= ent;
               end else begin
                  q0 <= q1;
                  q1 <= ent;
               end
            default: ;
         endcase
      end
   end

`ifdef PDU_TX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pkt_cnt <= '0;
         stat_err_cnt <= '0;
      end else begin
         if (pop & q0.eop) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
         if (err_evt)      stat_err_cnt <= stat_err_cnt + 32'd1;
      end
   end
`else
   assign stat_pkt_cnt = '0;
   assign stat_err_cnt = '0;
`endif

   assign unused_ok = &{1'b0, bus.in_sop, sz_sum[5:0], err_evt};
endmodule

// File: tb/tb_pdu_tx_framer.sv
// Scoreboard bench for pdu_tx_framer: queued drivers, negedge monitor.
// Counter expectations follow whether PDU_TX_STATS_EN is defined.
module tb_pdu_tx_framer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pdu_tx_framer_if bus ();
   logic [31:0] stat_pkt_cnt, stat_err_cnt;

   pdu_tx_framer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .stat_pkt_cnt (stat_pkt_cnt),
      .stat_err_cnt (stat_err_cnt)
   );

   typedef struct {
      logic [511:0] d;
      logic         sop;
      logic         eop;
   } flit_t;

   typedef struct {
      logic [511:0] d;
      logic         sop;
      logic         eop;
      logic [5:0]   emp;
   } exp_t;

   flit_t flit_q[$];
   int    meta_q[$];
   exp_t  exp_q[$];
   int    flit_cyc[$];
   int    meta_cyc[$];
   int    out_cyc[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    flush = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] mk_in(logic [7:0] s);
      logic [511:0] v;
      for (int i = 0; i < 64; i++) v[511-8*i -: 8] = s + 8'(i);
      return v;
   endfunction

   // wire order: host byte j ends up in bits [8j+7:8j]
   function automatic logic [511:0] mk_out(logic [7:0] s);
      logic [511:0] v;
      for (int j = 0; j < 64; j++) v[8*j +: 8] = s + 8'(j);
      return v;
   endfunction

   function automatic logic [31:0] st(int v);
`ifdef PDU_TX_STATS_EN
      return 32'(v);
`else
      return 32'(v) & 32'd0;
`endif
   endfunction

   task automatic chk(string nm, logic [527:0] act, logic [527:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_flit(logic [7:0] s, logic sop, logic eop);
      flit_t f;
      f.d = mk_in(s);
      f.sop = sop;
      f.eop = eop;
      flit_q.push_back(f);
   endtask

   task automatic push_exp(logic [7:0] s, logic sop, logic eop,
                           logic [5:0] emp);
      exp_t e;
      e.d = mk_out(s);
      e.sop = sop;
      e.eop = eop;
      e.emp = emp;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(string nm);
      int n = 0;
      while ((flit_q.size() != 0 || meta_q.size() != 0 ||
              exp_q.size() != 0 || bus.in_valid || bus.in_meta_valid)
             && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL %s_timeout: pending exp=%0d flits=%0d",
                  nm, exp_q.size(), flit_q.size());
      end
   endtask

   initial begin : flit_drv
      flit_t f;
      bit ok;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      forever begin
         if (flush || flit_q.size() == 0) begin
            @(posedge clk);
            #1;
         end else begin
            f = flit_q.pop_front();
            bus.in_data  = f.d;
            bus.in_sop   = f.sop;
            bus.in_eop   = f.eop;
            bus.in_valid = 1'b1;
            ok = 1'b0;
            while (!ok && !flush) begin
               @(negedge clk);
               ok = bus.in_ready;
               @(posedge clk);
               #1;
            end
            if (ok) flit_cyc.push_back(cyc);
            bus.in_valid = 1'b0;
         end
      end
   end

   initial begin : meta_drv
      bit ok;
      bus.in_meta_valid = 1'b0;
      bus.in_meta_size  = '0;
      forever begin
         if (flush || meta_q.size() == 0) begin
            @(posedge clk);
            #1;
         end else begin
            bus.in_meta_size  = 16'(meta_q.pop_front());
            bus.in_meta_valid = 1'b1;
            ok = 1'b0;
            while (!ok && !flush) begin
               @(negedge clk);
               ok = bus.in_meta_ready;
               @(posedge clk);
               #1;
            end
            if (ok) meta_cyc.push_back(cyc);
            bus.in_meta_valid = 1'b0;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      bit held = 1'b0;
      logic [527:0] hv;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held)
               chk("stall_hold",
                   {bus.out_valid, bus.out_sop, bus.out_eop,
                    bus.out_empty, bus.out_data}, hv);
            held = bus.out_valid && !bus.out_ready;
            hv = {1'b1, bus.out_sop, bus.out_eop,
                  bus.out_empty, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
               out_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got sop=%0b eop=%0b data=%0h",
                           bus.out_sop, bus.out_eop, bus.out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_flit",
                      {bus.out_sop, bus.out_eop, bus.out_empty, bus.out_data},
                      {e.sop, e.eop, e.emp, e.d});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int mi, fi, n, k;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_frame",
          {bus.out_sop, bus.out_eop, bus.out_empty}, 8'd0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_meta_ready", bus.in_meta_ready, 1'b1);
      chk("rst_stats", {stat_pkt_cnt, stat_err_cnt}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // single-flit packet, byte order + latency
      meta_q.push_back(64);
      push_flit(8'h00, 1'b1, 1'b1);
      push_exp(8'h00, 1'b1, 1'b1, 6'd0);
      wait_idle("t1");
      if (out_cyc.size() > 0 && flit_cyc.size() > 0)
         chk("latency", out_cyc[out_cyc.size()-1],
             flit_cyc[flit_cyc.size()-1]);
      else
         chk("latency_present", 1'b0, 1'b1);
      chk("t1_pkt_cnt", stat_pkt_cnt, st(1));

      // 130 bytes then back-to-back 64-byte packet
      mi = meta_cyc.size() + 1;
      fi = flit_cyc.size() + 2;
      meta_q.push_back(130);
      meta_q.push_back(64);
      push_flit(8'h10, 1'b1, 1'b0);
      push_flit(8'h20, 1'b0, 1'b0);
      push_flit(8'h30, 1'b0, 1'b1);
      push_flit(8'h40, 1'b1, 1'b1);
      push_exp(8'h10, 1'b1, 1'b0, 6'd0);
      push_exp(8'h20, 1'b0, 1'b0, 6'd0);
      push_exp(8'h30, 1'b0, 1'b1, 6'd62);
      push_exp(8'h40, 1'b1, 1'b1, 6'd0);
      wait_idle("t2");
      if (meta_cyc.size() > mi && flit_cyc.size() > fi)
         chk("b2b_meta_cycle", meta_cyc[mi], flit_cyc[fi]);
      else
         chk("b2b_hs_present", 1'b0, 1'b1);
      chk("t2_pkt_cnt", stat_pkt_cnt, st(3));

      // descriptor shorter than flit stream: surplus dropped
      meta_q.push_back(100);
      push_flit(8'h50, 1'b1, 1'b0);
      push_flit(8'h60, 1'b0, 1'b0);
      push_flit(8'h70, 1'b0, 1'b0);
      push_flit(8'h80, 1'b0, 1'b1);
      push_exp(8'h50, 1'b1, 1'b0, 6'd0);
      push_exp(8'h60, 1'b0, 1'b1, 6'd28);
      wait_idle("t3");
      chk("t3_err_cnt", stat_err_cnt, st(1));
      chk("t3_pkt_cnt", stat_pkt_cnt, st(4));

      // early in_eop
      meta_q.push_back(256);
      push_flit(8'h90, 1'b1, 1'b0);
      push_flit(8'ha0, 1'b0, 1'b1);
      push_exp(8'h90, 1'b1, 1'b0, 6'd0);
      push_exp(8'ha0, 1'b0, 1'b1, 6'd0);
      wait_idle("t4");
      chk("t4_err_cnt", stat_err_cnt, st(2));
      chk("t4_idle_meta_ready", bus.in_meta_ready, 1'b1);
      chk("t4_in_ready", bus.in_ready, 1'b0);

      // zero-size descriptor: whole packet dropped
      meta_q.push_back(0);
      push_flit(8'hb0, 1'b1, 1'b1);
      wait_idle("zero");
      chk("zero_err_cnt", stat_err_cnt, st(3));
      chk("zero_meta_ready", bus.in_meta_ready, 1'b1);

      // 65 bytes: one valid byte in the eop flit
      meta_q.push_back(65);
      push_flit(8'hc0, 1'b1, 1'b0);
      push_flit(8'hd0, 1'b0, 1'b1);
      push_exp(8'hc0, 1'b1, 1'b0, 6'd0);
      push_exp(8'hd0, 1'b0, 1'b1, 6'd63);
      wait_idle("s65");
      chk("s65_pkt_cnt", stat_pkt_cnt, st(6));

      // MAC backpressure after first flit
      n = flit_cyc.size();
      meta_q.push_back(192);
      push_flit(8'he0, 1'b1, 1'b0);
      push_flit(8'hf0, 1'b0, 1'b0);
      push_flit(8'h01, 1'b0, 1'b1);
      push_exp(8'he0, 1'b1, 1'b0, 6'd0);
      push_exp(8'hf0, 1'b0, 1'b0, 6'd0);
      push_exp(8'h01, 1'b0, 1'b1, 6'd0);
      k = 0;
      while (flit_cyc.size() == n && k < 200) begin
         @(posedge clk);
         #2;
         k++;
      end
      bus.out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_accepted", flit_cyc.size() - n, 2);
      bus.out_ready = 1'b1;
      wait_idle("t5");
      chk("t5_pkt_cnt", stat_pkt_cnt, st(7));

      // async reset in the middle of the second packet
      n = flit_cyc.size();
      meta_q.push_back(64);
      meta_q.push_back(192);
      push_flit(8'h11, 1'b1, 1'b1);
      push_flit(8'h22, 1'b1, 1'b0);
      push_flit(8'h33, 1'b0, 1'b0);
      push_flit(8'h44, 1'b0, 1'b1);
      push_exp(8'h11, 1'b1, 1'b1, 6'd0);
      push_exp(8'h22, 1'b1, 1'b0, 6'd0);
      k = 0;
      while (flit_cyc.size() < n + 2 && k < 200) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk("t6_reached_mid", flit_cyc.size() - n, 2);
      flush = 1'b1;
      flit_q.delete();
      meta_q.delete();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_out", {bus.out_valid, bus.out_sop, bus.out_eop,
                         bus.out_empty, bus.out_data}, '0);
      chk("t6_rst_ready", {bus.in_ready, bus.in_meta_ready}, 2'b01);
      chk("t6_rst_stats", {stat_pkt_cnt, stat_err_cnt}, 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      flush = 1'b0;
      meta_q.push_back(64);
      push_flit(8'h55, 1'b1, 1'b1);
      push_exp(8'h55, 1'b1, 1'b1, 6'd0);
      wait_idle("t6");
      chk("t6_pkt_cnt", stat_pkt_cnt, st(1));
      chk("drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
